// File: rtl/instr_cache_pkg.sv
// Shared constants, FSM state type and address helper for the instruction cache.
package instr_cache_pkg;

    localparam int PC_LENGTH     = 32;
    localparam int INSTR_LENGTH  = 32;
    localparam int IC_INDEX_BITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    function automatic logic [PC_LENGTH-1:0] word_addr(input logic [PC_LENGTH-1:0] pc);
        return {pc[PC_LENGTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Direct-mapped valid/tag/data storage: one combinational read port, one synchronous write port.
module instr_cache_array
    import instr_cache_pkg::*;
#(
    parameter int IndexBits = IC_INDEX_BITS,
    parameter int TagBits   = PC_LENGTH - IndexBits - 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IndexBits-1:0]    rd_index,
    output logic                    rd_valid,
    output logic [TagBits-1:0]      rd_tag,
    output logic [INSTR_LENGTH-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [IndexBits-1:0]    wr_index,
    input  logic [TagBits-1:0]      wr_tag,
    input  logic [INSTR_LENGTH-1:0] wr_data
);

    localparam int Lines = 2 ** IndexBits;

    logic [Lines-1:0]        valid_q;
    logic [Lines-1:0]        valid_d;
    logic [TagBits-1:0]      tag_mem  [Lines];
    logic [INSTR_LENGTH-1:0] data_mem [Lines];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/instr_cache.sv
// Instruction cache: lookup of the queue's fetch PC, byte-serial miss fill from the
// memory controller, and duplicate suppression of the PC just served.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int IndexBits = IC_INDEX_BITS,
    parameter int TagBits   = PC_LENGTH - IndexBits - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_exception_from_rob,
    input  logic        is_empty_from_iq,
    input  logic [31:0] pc_from_iq,
    output logic        is_hit_to_iq,
    output logic [31:0] instr_to_iq,
    output logic        is_req_to_mc,
    output logic [31:0] addr_to_mc,
    input  logic        is_valid_from_mc,
    input  logic [7:0]  data_from_mc
);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [23:0]             bytes_q, bytes_d;
    logic [PC_LENGTH-1:0]    req_pc_q, req_pc_d;
    logic                    served_q, served_d;
    logic [PC_LENGTH-1:0]    served_pc_q, served_pc_d;
    logic                    hit_q, hit_d;
    logic [INSTR_LENGTH-1:0] instr_q, instr_d;
    logic                    req_q, req_d;
    logic [PC_LENGTH-1:0]    addr_q, addr_d;

    logic                    rd_valid;
    logic [TagBits-1:0]      rd_tag;
    logic [INSTR_LENGTH-1:0] rd_data;
    logic                    fill_we;
    logic                    lookup_hit;
    logic                    accept;

    instr_cache_array #(
        .IndexBits (IndexBits),
        .TagBits   (TagBits)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (pc_from_iq[IndexBits+1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_we && !rst),
        .wr_index (req_pc_q[IndexBits+1:2]),
        .wr_tag   (req_pc_q[PC_LENGTH-1 -: TagBits]),
        .wr_data  ({data_from_mc, bytes_q})
    );

    assign lookup_hit = rd_valid && (rd_tag == pc_from_iq[PC_LENGTH-1 -: TagBits]);
    // The queue keeps presenting a served PC for a couple of cycles; do not serve it twice.
    assign accept = (state_q == IDLE) && !is_empty_from_iq
                    && !(served_q && (pc_from_iq == served_pc_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bytes_d     = bytes_q;
        req_pc_d    = req_pc_q;
        served_d    = served_q;
        served_pc_d = served_pc_q;
        hit_d       = 1'b0;
        instr_d     = instr_q;
        req_d       = req_q;
        addr_d      = addr_q;
        fill_we     = 1'b0;
        if (is_exception_from_rob) begin
            state_d  = IDLE;
            req_d    = 1'b0;
            cnt_d    = 2'd0;
            served_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_pc_d = pc_from_iq;
                        if (lookup_hit) begin
                            hit_d       = 1'b1;
                            instr_d     = rd_data;
                            served_d    = 1'b1;
                            served_pc_d = pc_from_iq;
                        end else begin
                            state_d = FILL;
                            req_d   = 1'b1;
                            addr_d  = word_addr(pc_from_iq);
                            cnt_d   = 2'd0;
                        end
                    end
                end
                FILL: begin
                    if (is_valid_from_mc) begin
                        cnt_d = cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: bytes_d[7:0]   = data_from_mc;
                            2'd1: bytes_d[15:8]  = data_from_mc;
                            2'd2: bytes_d[23:16] = data_from_mc;
                            default: begin
                                fill_we     = 1'b1;
                                hit_d       = 1'b1;
                                instr_d     = {data_from_mc, bytes_q};
                                req_d       = 1'b0;
                                served_d    = 1'b1;
                                served_pc_d = req_pc_q;
                                state_d     = IDLE;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            served_q <= 1'b0;
            hit_q    <= 1'b0;
            instr_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            served_q <= served_d;
            hit_q    <= hit_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
        end
        bytes_q     <= bytes_d;
        req_pc_q    <= req_pc_d;
        served_pc_q <= served_pc_d;
    end

    assign is_hit_to_iq = hit_q;
    assign instr_to_iq  = instr_q;
    assign is_req_to_mc = req_q;
    assign addr_to_mc   = addr_q;

endmodule
